// File: rtl/aes_enc_iter.sv
// Iterative AES-128/256 encryptor: one round per clock, round keys expanded on the fly, valid/ready on both sides.
// Optional AES_KEY_REUSE_EN adds in_reuse_key and a stored cipher-key register.
module aes_enc_iter #(
  parameter int KEY_BITS = 128
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [127:0]        in_data,
  input  logic [KEY_BITS-1:0] in_key,
`ifdef AES_KEY_REUSE_EN
  input  logic                in_reuse_key,
`endif
  output logic                out_valid,
  input  logic                out_ready,
  output logic [127:0]        out_data
);

  localparam int         NR   = KEY_BITS / 32 + 6;
  localparam logic [3:0] NR_C = 4'(NR);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  generate
    if (KEY_BITS != 128 && KEY_BITS != 256) begin : g_bad_key
      $error("aes_enc_iter: KEY_BITS must be 128 or 256");
    end
  endgenerate

  // Entry 0 sits in the top byte, so entry b lives at bit offset 8*(255-b) = {~b, 3'b000}.
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    sbox = SBOX_TBL[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    sub_word = {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  // Byte 0 of a word is its least significant byte, so RotWord is a right rotate by 8.
  function automatic logic [31:0] rot_word(input logic [31:0] w);
    rot_word = {w[7:0], w[31:8]};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] i);
    case (i)
      4'd0:    rcon = 8'h01;
      4'd1:    rcon = 8'h02;
      4'd2:    rcon = 8'h04;
      4'd3:    rcon = 8'h08;
      4'd4:    rcon = 8'h10;
      4'd5:    rcon = 8'h20;
      4'd6:    rcon = 8'h40;
      4'd7:    rcon = 8'h80;
      4'd8:    rcon = 8'h1b;
      4'd9:    rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    a0 = c[7:0];
    a1 = c[15:8];
    a2 = c[23:16];
    a3 = c[31:24];
    mix_col = {xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3),
               a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
               a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
               xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3};
  endfunction

  // Row r of column c takes the byte from column (c+r) mod 4.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    shift_rows = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        shift_rows[8*(r+4*c) +: 8] = s[8*(r+4*((c+r)%4)) +: 8];
      end
    end
  endfunction

  logic [1:0]          fsm_q, fsm_d;
  logic [3:0]          rnd_q, rnd_d;
  logic [127:0]        st_q, st_d;
  logic [KEY_BITS-1:0] key_q, key_d;
  logic                out_valid_q, out_valid_d;
  logic [127:0]        out_data_q, out_data_d;

  logic [KEY_BITS-1:0] key_nxt;
  logic [KEY_BITS-1:0] acc_key;
  logic [127:0]        rk;
  logic [127:0]        sb, sr, mc, round_out;
  logic                accept;

  // The round key is always the top 128 bits of the window after this cycle's expansion.
  generate
    if (KEY_BITS == 256) begin : g_ks256
      logic [3:0]  step;
      logic [31:0] tmp, n0, n1, n2, n3;
      always_comb begin
        step = rnd_q - 4'd2;
        tmp  = step[0] ? sub_word(key_q[255:224])
                       : sub_word(rot_word(key_q[255:224])) ^ {24'h0, rcon({1'b0, step[3:1]})};
        n0 = key_q[31:0]   ^ tmp;
        n1 = key_q[63:32]  ^ n0;
        n2 = key_q[95:64]  ^ n1;
        n3 = key_q[127:96] ^ n2;
        // Round 1 uses w[4..7] straight from the cipher key; expansion starts at round 2.
        key_nxt = (rnd_q == 4'd1) ? key_q : {n3, n2, n1, n0, key_q[255:128]};
      end
    end else begin : g_ks128
      logic [31:0] tmp, n0, n1, n2, n3;
      always_comb begin
        tmp = sub_word(rot_word(key_q[127:96])) ^ {24'h0, rcon(rnd_q - 4'd1)};
        n0  = key_q[31:0]   ^ tmp;
        n1  = key_q[63:32]  ^ n0;
        n2  = key_q[95:64]  ^ n1;
        n3  = key_q[127:96] ^ n2;
        key_nxt = {n3, n2, n1, n0};
      end
    end
  endgenerate

  assign rk = key_nxt[KEY_BITS-1 -: 128];

  always_comb begin
    sb = '0;
    mc = '0;
    for (int i = 0; i < 16; i++) begin
      sb[8*i +: 8] = sbox(st_q[8*i +: 8]);
    end
    sr = shift_rows(sb);
    for (int c = 0; c < 4; c++) begin
      mc[32*c +: 32] = mix_col(sr[32*c +: 32]);
    end
    round_out = ((rnd_q == NR_C) ? sr : mc) ^ rk;
  end

`ifdef AES_KEY_REUSE_EN
  logic [KEY_BITS-1:0] ckey_q, ckey_d;

  always_comb begin
    acc_key = in_reuse_key ? ckey_q : in_key;
    ckey_d  = (accept && !in_reuse_key) ? in_key : ckey_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ckey_q <= '0;
    else     ckey_q <= ckey_d;
  end
`else
  assign acc_key = in_key;
`endif

  assign in_ready = (fsm_q == S_IDLE) || ((fsm_q == S_DONE) && out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    fsm_d       = fsm_q;
    rnd_d       = rnd_q;
    st_d        = st_q;
    key_d       = key_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    case (fsm_q)
      S_IDLE: ;
      S_RUN: begin
        if (rnd_q == NR_C) begin
          out_data_d  = round_out;
          out_valid_d = 1'b1;
          fsm_d       = S_DONE;
        end else begin
          st_d  = round_out;
          key_d = key_nxt;
          rnd_d = rnd_q + 4'd1;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          fsm_d       = S_IDLE;
        end
      end
      default: fsm_d = S_IDLE;
    endcase
    // An accept in DONE overrides the return to IDLE.
    if (accept) begin
      st_d  = in_data ^ acc_key[127:0];
      key_d = acc_key;
      rnd_d = 4'd1;
      fsm_d = S_RUN;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q       <= S_IDLE;
      rnd_q       <= '0;
      st_q        <= '0;
      key_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      fsm_q       <= fsm_d;
      rnd_q       <= rnd_d;
      st_q        <= st_d;
      key_q       <= key_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_aes_enc_iter.sv
// Bench for aes_enc_iter: AES-128 and AES-256 instances checked against FIPS-197 vectors and a table-free AES model.
module tb_aes_enc_iter;

  localparam logic [255:0] K128 = {128'h0, 128'h0f0e0d0c0b0a09080706050403020100};
  localparam logic [255:0] K256 = 256'h1f1e1d1c1b1a191817161514131211100f0e0d0c0b0a09080706050403020100;
  localparam logic [127:0] PT    = 128'hffeeddccbbaa99887766554433221100;
  localparam logic [127:0] CT128 = 128'h5ac5b47080b7cdd830047b6ad8e0c469;
  localparam logic [127:0] CT256 = 128'h8960494b9049fceabf456751cab7a28e;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] in_data;
  logic [255:0] in_key;
  logic         in_valid    [2];
  logic         out_ready   [2];
  logic         in_ready_s  [2];
  logic         out_valid_s [2];
  logic [127:0] out_data_s  [2];
`ifdef AES_KEY_REUSE_EN
  logic         reuse_key;
`endif

  int vectors     = 0;
  int miscompares = 0;
  logic [7:0] sbox_t [256];

  always #5 clk = ~clk;

  aes_enc_iter #(.KEY_BITS(128)) dut128 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[0]), .in_ready(in_ready_s[0]),
    .in_data(in_data), .in_key(in_key[127:0]),
`ifdef AES_KEY_REUSE_EN
    .in_reuse_key(reuse_key),
`endif
    .out_valid(out_valid_s[0]), .out_ready(out_ready[0]), .out_data(out_data_s[0])
  );

  aes_enc_iter #(.KEY_BITS(256)) dut256 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[1]), .in_ready(in_ready_s[1]),
    .in_data(in_data), .in_key(in_key),
`ifdef AES_KEY_REUSE_EN
    .in_reuse_key(reuse_key),
`endif
    .out_valid(out_valid_s[1]), .out_ready(out_ready[1]), .out_data(out_data_s[1])
  );

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  // S-box from the multiplicative inverse and the affine map, not from a table.
  task automatic build_sbox();
    for (int b = 0; b < 256; b++) begin
      logic [7:0] inv, r1, r2, r3, r4;
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gmul(8'(b), 8'(y)) == 8'h01) inv = 8'(y);
      end
      r1 = {inv[6:0], inv[7]};
      r2 = {r1[6:0], r1[7]};
      r3 = {r2[6:0], r2[7]};
      r4 = {r3[6:0], r3[7]};
      sbox_t[b] = inv ^ r1 ^ r2 ^ r3 ^ r4 ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] sub_word_ref(input logic [31:0] t);
    return {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
  endfunction

  function automatic logic [127:0] aes_ref(input logic [255:0] key, input int nk, input logic [127:0] pt);
    logic [31:0]  w   [60];
    logic [7:0]   st  [16];
    logic [7:0]   tmp [16];
    logic [31:0]  t;
    logic [7:0]   rc, a0, a1, a2, a3;
    logic [127:0] res;
    int nr;
    nr = nk + 6;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[32*i +: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t = sub_word_ref({t[7:0], t[31:8]});
        t[7:0] = t[7:0] ^ rc;
        rc = gmul(rc, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        t = sub_word_ref(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int i = 0; i < 16; i++) st[i] = pt[8*i +: 8] ^ w[i/4][8*(i%4) +: 8];
    for (int r = 1; r <= nr; r++) begin
      for (int i = 0; i < 16; i++) st[i] = sbox_t[st[i]];
      for (int c = 0; c < 4; c++)
        for (int j = 0; j < 4; j++) tmp[j+4*c] = st[j+4*((c+j)%4)];
      for (int c = 0; c < 4; c++) begin
        a0 = tmp[4*c]; a1 = tmp[4*c+1]; a2 = tmp[4*c+2]; a3 = tmp[4*c+3];
        if (r < nr) begin
          st[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
          st[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
          st[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
          st[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end else begin
          st[4*c] = a0; st[4*c+1] = a1; st[4*c+2] = a2; st[4*c+3] = a3;
        end
      end
      for (int i = 0; i < 16; i++) st[i] = st[i] ^ w[4*r + i/4][8*(i%4) +: 8];
    end
    res = '0;
    for (int i = 0; i < 16; i++) res[8*i +: 8] = st[i];
    return res;
  endfunction

  // ---------------- drivers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] rand256();
    return {$urandom(), $urandom(), $urandom(), $urandom(),
            $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Offers one block and returns just after the accept edge; inputs are then scrambled.
  task automatic send(input int s, input logic [255:0] k, input logic [127:0] pt);
    int n;
    n = 0;
    in_key = k;
    in_data = pt;
    in_valid[s] = 1'b1;
    #1;
    while (!in_ready_s[s] && n < 40) begin
      tick();
      #1;
      n++;
    end
    vectors++;
    if (in_ready_s[s] !== 1'b1) begin
      miscompares++;
      $display("FAIL accept_timeout dut%0d: in_ready=%b after %0d cycles, want 1", s, in_ready_s[s], n);
    end
    tick();
    in_valid[s] = 1'b0;
    in_key = rand256();
    in_data = rand256()[127:0];
  endtask

  task automatic wait_out(input int s, output int cyc);
    cyc = 0;
    while (!out_valid_s[s] && cyc < 40) begin
      tick();
      cyc++;
    end
  endtask

  task automatic take(input int s);
    out_ready[s] = 1'b1;
    tick();
    out_ready[s] = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    for (int s = 0; s < 2; s++) begin
      vectors++;
      if (in_ready_s[s] !== 1'b1) begin
        miscompares++;
        $display("FAIL reset_in_ready dut%0d: got %b want 1", s, in_ready_s[s]);
      end
      vectors++;
      if (out_valid_s[s] !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_out_valid dut%0d: got %b want 0", s, out_valid_s[s]);
      end
      vectors++;
      if (out_data_s[s] !== 128'h0) begin
        miscompares++;
        $display("FAIL reset_out_data dut%0d: got %h want 0", s, out_data_s[s]);
      end
    end
  endtask

  task automatic test_known(input int s);
    int lat, nr;
    logic [127:0] exp;
    nr  = s ? 14 : 10;
    exp = s ? CT256 : CT128;
    send(s, s ? K256 : K128, PT);
    wait_out(s, lat);
    vectors++;
    if (lat !== nr) begin
      miscompares++;
      $display("FAIL known_latency dut%0d: got %0d cycles want %0d", s, lat, nr);
    end
    vectors++;
    if (out_data_s[s] !== exp) begin
      miscompares++;
      $display("FAIL known_ct dut%0d: got %h want %h", s, out_data_s[s], exp);
    end
    take(s);
  endtask

  task automatic test_random(input int s, input int n);
    int lat;
    logic [255:0] k;
    logic [127:0] pt, exp;
    for (int i = 0; i < n; i++) begin
      k   = rand256();
      pt  = rand256()[127:0];
      exp = aes_ref(k, s ? 8 : 4, pt);
      send(s, k, pt);
      // Offer junk during the run; it must be ignored.
      in_valid[s] = 1'b1;
      wait_out(s, lat);
      in_valid[s] = 1'b0;
      repeat ($urandom_range(0, 3)) tick();
      vectors++;
      if (out_data_s[s] !== exp || out_valid_s[s] !== 1'b1) begin
        miscompares++;
        $display("FAIL random_ct dut%0d #%0d: got %h (vld %b) want %h", s, i, out_data_s[s], out_valid_s[s], exp);
      end
      take(s);
    end
  endtask

  task automatic test_backpressure();
    int lat;
    logic [255:0] k;
    logic [127:0] pt, exp;
    k   = rand256();
    pt  = rand256()[127:0];
    exp = aes_ref(k, 4, pt);
    send(0, k, pt);
    wait_out(0, lat);
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (out_data_s[0] !== exp || out_valid_s[0] !== 1'b1) begin
        miscompares++;
        $display("FAIL bp_hold cyc%0d: got %h (vld %b) want %h", i, out_data_s[0], out_valid_s[0], exp);
      end
      vectors++;
      if (in_ready_s[0] !== 1'b0) begin
        miscompares++;
        $display("FAIL bp_in_ready cyc%0d: got %b want 0", i, in_ready_s[0]);
      end
      tick();
    end
    out_ready[0] = 1'b1;
    #1;
    vectors++;
    if (in_ready_s[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_in_ready_follow: got %b want 1", in_ready_s[0]);
    end
    tick();
    out_ready[0] = 1'b0;
    #1;
    vectors++;
    if (out_valid_s[0] !== 1'b0 || in_ready_s[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_single_handshake: vld %b rdy %b want 0 1", out_valid_s[0], in_ready_s[0]);
    end
  endtask

  task automatic test_back_to_back(input int s);
    int nacc, nout, nr;
    int acc_c [2];
    int out_c [2];
    logic [127:0] out_d [2];
    logic [127:0] exp;
    nr  = s ? 14 : 10;
    exp = s ? CT256 : CT128;
    acc_c = '{-1, -1};
    out_c = '{-1, -1};
    out_d = '{128'h0, 128'h0};
    nacc = 0;
    nout = 0;
    in_key = s ? K256 : K128;
    in_data = PT;
    in_valid[s] = 1'b1;
    out_ready[s] = 1'b1;
    for (int cyc = 0; cyc < 60 && nout < 2; cyc++) begin
      if (nacc >= 2) in_valid[s] = 1'b0;
      #1;
      if (in_valid[s] && in_ready_s[s]) begin
        if (nacc < 2) acc_c[nacc] = cyc;
        nacc++;
      end
      if (out_valid_s[s]) begin
        if (nout < 2) begin
          out_c[nout] = cyc;
          out_d[nout] = out_data_s[s];
        end
        nout++;
      end
      tick();
    end
    in_valid[s] = 1'b0;
    out_ready[s] = 1'b0;
    vectors++;
    if (acc_c[1] !== out_c[0]) begin
      miscompares++;
      $display("FAIL b2b_accept_in_done dut%0d: 2nd accept cyc %0d, 1st output cyc %0d", s, acc_c[1], out_c[0]);
    end
    vectors++;
    if (out_c[1] - out_c[0] !== nr + 1) begin
      miscompares++;
      $display("FAIL b2b_spacing dut%0d: got %0d cycles want %0d", s, out_c[1] - out_c[0], nr + 1);
    end
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (out_d[i] !== exp) begin
        miscompares++;
        $display("FAIL b2b_ct dut%0d #%0d: got %h want %h", s, i, out_d[i], exp);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit saw;
    send(0, K128, PT);
    repeat (4) tick();
    rst = 1'b1;
    #1;
    vectors++;
    if (out_valid_s[0] !== 1'b0 || in_ready_s[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL midrst_async: vld %b rdy %b want 0 1", out_valid_s[0], in_ready_s[0]);
    end
    tick();
    rst = 1'b0;
    saw = 1'b0;
    repeat (14) begin
      tick();
      if (out_valid_s[0]) saw = 1'b1;
    end
    vectors++;
    if (saw !== 1'b0 || in_ready_s[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL midrst_abort: saw out_valid %b, in_ready %b, want 0 1", saw, in_ready_s[0]);
    end
    test_known(0);
  endtask

`ifdef AES_KEY_REUSE_EN
  task automatic test_key_reuse(input int s);
    int lat;
    logic [127:0] exp;
    exp = s ? CT256 : CT128;
    reuse_key = 1'b0;
    send(s, s ? K256 : K128, PT);
    wait_out(s, lat);
    take(s);
    reuse_key = 1'b1;
    send(s, 256'h0, PT);
    reuse_key = 1'b0;
    wait_out(s, lat);
    vectors++;
    if (out_data_s[s] !== exp) begin
      miscompares++;
      $display("FAIL key_reuse_ct dut%0d: got %h want %h", s, out_data_s[s], exp);
    end
    take(s);
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    in_data = '0;
    in_key = '0;
    for (int s = 0; s < 2; s++) begin
      in_valid[s] = 1'b0;
      out_ready[s] = 1'b0;
    end
`ifdef AES_KEY_REUSE_EN
    reuse_key = 1'b0;
`endif
    build_sbox();
    repeat (3) tick();
    test_reset();
    rst = 1'b0;
    tick();
    test_reset();
    test_known(0);
    test_known(1);
    test_random(0, 6);
    test_random(1, 6);
    test_backpressure();
    test_back_to_back(0);
    test_back_to_back(1);
    test_reset_mid();
`ifdef AES_KEY_REUSE_EN
    test_key_reuse(0);
    test_key_reuse(1);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
